// File: rtl/reg_mem_fifo_ctrl.sv
// reg_mem_fifo_ctrl: valid/ready FIFO sequencer around one reg_mem, with a 2-entry output skid
// that hides the registered-read latency. Define REG_MEM_FIFO_ERR_CHK_EN to add err_sticky.
`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 16
`endif
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 3
`endif
`ifndef LIM_BRICK_WORD_NUM
`define LIM_BRICK_WORD_NUM 8
`endif

module reg_mem_fifo_ctrl #(
   parameter int BL_WIDTH   = `LIM_BRICK_WORD_SIZE,
   parameter int ADDR_WIDTH = `BITS_ADDR_LIM_BRICK,
   parameter int DEPTH      = `LIM_BRICK_WORD_NUM
) (
   input  logic                  CLK,
   input  logic                  rst_b,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BL_WIDTH-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BL_WIDTH-1:0]   out_data,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [BL_WIDTH-1:0]   mem_wbl,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [BL_WIDTH-1:0]   mem_arbl,
   output logic [ADDR_WIDTH+1:0] occupancy
`ifdef REG_MEM_FIFO_ERR_CHK_EN
   ,
   output logic                  err_sticky
`endif
);

   localparam logic [ADDR_WIDTH:0]   MEM_FULL  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   mem_cnt;
   logic [ADDR_WIDTH:0]   mem_cnt_nxt;
   logic                  in_ready_q;
   logic                  inflight;
   logic [1:0]            skid_cnt;
   logic [BL_WIDTH-1:0]   skid0;
   logic [BL_WIDTH-1:0]   skid1;
   logic [2:0]            skid_load;
   logic                  push;
   logic                  pop;
   logic                  issue;

   // A read may issue only if the skid can still hold everything already owed to it
   always_comb begin
      push        = in_valid & in_ready_q & ~flush;
      pop         = (skid_cnt != 2'd0) & out_ready;
      skid_load   = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
      issue       = ~flush & (mem_cnt != '0) & (skid_load < 3'd2);
      mem_cnt_nxt = mem_cnt;
      if (flush)
         mem_cnt_nxt = '0;
      else if (push & ~issue)
         mem_cnt_nxt = mem_cnt + CNT_ONE;
      else if (issue & ~push)
         mem_cnt_nxt = mem_cnt - CNT_ONE;
   end

   assign in_ready    = in_ready_q;
   assign mem_wr_en   = push;
   assign mem_wr_addr = wr_ptr;
   assign mem_wbl     = in_data;
   assign mem_rd_en   = issue;
   assign mem_rd_addr = rd_ptr;
   assign out_valid   = (skid_cnt != 2'd0);
   assign out_data    = skid0;
   assign occupancy   = {1'b0, mem_cnt} + (ADDR_WIDTH+2)'(skid_cnt) + (ADDR_WIDTH+2)'(inflight);

   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_cnt    <= '0;
         inflight   <= 1'b0;
         in_ready_q <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_cnt    <= '0;
         inflight   <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + PTR_ONE;
         if (issue)
            rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + PTR_ONE;
         mem_cnt    <= mem_cnt_nxt;
         inflight   <= issue;
         in_ready_q <= (mem_cnt_nxt < MEM_FULL);
      end
   end

   // skid0 is always the head; a pop shifts skid1 forward, the returning read lands at the tail
   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         skid_cnt <= 2'd0;
         skid0    <= '0;
         skid1    <= '0;
      end else if (flush) begin
         skid_cnt <= 2'd0;
      end else begin
         case ({inflight, pop})
            2'b10: begin
               if (skid_cnt == 2'd0)
                  skid0 <= mem_arbl;
               else
                  skid1 <= mem_arbl;
               skid_cnt <= skid_cnt + 2'd1;
            end
            2'b01: begin
               skid0    <= skid1;
               skid_cnt <= skid_cnt - 2'd1;
            end
            2'b11: begin
               if (skid_cnt == 2'd1)
                  skid0 <= mem_arbl;
               else begin
                  skid0 <= skid1;
                  skid1 <= mem_arbl;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef REG_MEM_FIFO_ERR_CHK_EN
   logic [1:0] stall_cnt;
   logic       stall_cond;
   logic       push_err;
   logic       err_set;

   assign stall_cond = out_ready & ~out_valid & (mem_cnt != '0);
   assign push_err   = in_valid & ~in_ready_q;
   assign err_set    = push_err | (stall_cond & (stall_cnt >= 2'd2));

   // Third consecutive starved cycle counts as a stall
   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         stall_cnt  <= 2'd0;
         err_sticky <= 1'b0;
      end else if (flush) begin
         stall_cnt  <= 2'd0;
         err_sticky <= 1'b0;
      end else begin
         if (!stall_cond)
            stall_cnt <= 2'd0;
         else if (stall_cnt != 2'd3)
            stall_cnt <= stall_cnt + 2'd1;
         if (err_set)
            err_sticky <= 1'b1;
      end
   end

   assert property (@(posedge CLK) disable iff (!rst_b) !(~flush & err_set));
`endif

endmodule

// File: tb/tb_reg_mem_fifo_ctrl.sv
// tb_reg_mem_fifo_ctrl: scoreboard bench for reg_mem_fifo_ctrl with a behavioural reg_mem
// and a queue-based FIFO reference model.
module tb_reg_mem_fifo_ctrl;

   localparam int BL_WIDTH   = 16;
   localparam int ADDR_WIDTH = 3;
   localparam int DEPTH      = 6;

   logic                  CLK = 1'b0;
   logic                  rst_b = 1'b0;
   logic                  flush = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  out_ready = 1'b0;
   logic [BL_WIDTH-1:0]   in_data = '0;
   logic                  in_ready;
   logic                  out_valid;
   logic [BL_WIDTH-1:0]   out_data;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [BL_WIDTH-1:0]   mem_wbl;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [BL_WIDTH-1:0]   mem_arbl = '0;
   logic [ADDR_WIDTH+1:0] occupancy;
`ifdef REG_MEM_FIFO_ERR_CHK_EN
   logic                  err_sticky;
`endif

   logic [BL_WIDTH-1:0] mem_array [2**ADDR_WIDTH];
   bit                  mem_valid [2**ADDR_WIDTH];
   logic [BL_WIDTH-1:0] exp_q [$];
   int                  total = 0;
   int                  bad = 0;

   always #5 CLK = ~CLK;

   reg_mem_fifo_ctrl #(.BL_WIDTH(BL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .rst_b(rst_b), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wbl(mem_wbl),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_arbl(mem_arbl),
      .occupancy(occupancy)
`ifdef REG_MEM_FIFO_ERR_CHK_EN
      , .err_sticky(err_sticky)
`endif
   );

   // Behavioural reg_mem: write on the edge, registered read data the cycle after issue
   always @(posedge CLK) begin
      if (mem_wr_en)
         mem_array[mem_wr_addr] <= mem_wbl;
      if (mem_rd_en)
         mem_arbl <= mem_array[mem_rd_addr];
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: occupancy equals words accepted but not yet delivered; outputs pop the scoreboard
   always @(negedge CLK) begin
      if (!rst_b) begin
         exp_q.delete();
         for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_valid[i] = 1'b0;
      end else begin
         check_output("occupancy", occupancy, exp_q.size());
         if (mem_rd_en) begin
            check_output("rd_of_unwritten_word", mem_valid[mem_rd_addr], 1);
            mem_valid[mem_rd_addr] = 1'b0;
         end
         if (mem_wr_en) begin
            check_output("wr_addr_in_range", (mem_wr_addr < DEPTH), 1);
            check_output("overwrite_unread_word", mem_valid[mem_wr_addr], 0);
            mem_valid[mem_wr_addr] = 1'b1;
         end
         if (flush) begin
            exp_q.delete();
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_valid[i] = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               check_output("pop_has_expected_word", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0)
                  check_output("out_data", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready)
               exp_q.push_back(in_data);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_stimulus(input logic iv, input logic [BL_WIDTH-1:0] d, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic push_word(input logic [BL_WIDTH-1:0] v);
      int k;
      in_valid = 1'b1;
      in_data  = v;
      k = 0;
      @(negedge CLK);
      while (!in_ready && k < 50) begin
         @(negedge CLK);
         k++;
      end
      check_output("push_accepted", in_ready, 1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int k;
      k = 0;
      while (!out_valid && k < budget) begin
         step();
         k++;
      end
      check_output("out_valid_seen", out_valid, 1);
   endtask

   task automatic wait_drain(input int budget);
      int k;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (occupancy != 0 && k < budget) begin
         step();
         k++;
      end
      check_output("drained", occupancy, 0);
      check_output("drained_out_valid", out_valid, 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int accepted;

      // Reset state and single-word latency
      repeat (3) step();
      check_output("rst_in_ready", in_ready, 0);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_occupancy", occupancy, 0);
      check_output("rst_out_data", out_data, 0);
      check_output("rst_mem_wr_en", mem_wr_en, 0);
      check_output("rst_mem_rd_en", mem_rd_en, 0);
`ifdef REG_MEM_FIFO_ERR_CHK_EN
      check_output("rst_err_sticky", err_sticky, 0);
`endif
      rst_b = 1'b1;
      check_output("in_ready_before_first_edge", in_ready, 0);
      step();
      check_output("in_ready_after_first_edge", in_ready, 1);
      apply_stimulus(1'b1, 16'h000A, 1'b1);
      step();
      in_valid = 1'b0;
      check_output("t1_rd_issue_cycle2", mem_rd_en, 1);
      check_output("t1_rd_addr", mem_rd_addr, 0);
      step();
      check_output("t1_no_early_valid", out_valid, 0);
      step();
      check_output("t1_out_valid", out_valid, 1);
      check_output("t1_out_data", out_data, 16'h000A);
      step();
      check_output("t1_occupancy_after_pop", occupancy, 0);
      check_output("t1_out_valid_after_pop", out_valid, 0);

      // Full-rate stream across three pointer wraps
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 3*DEPTH; i++) push_word(BL_WIDTH'(16'h0100 + i));
            in_valid = 1'b0;
         end
         begin
            int k;
            k = 0;
            @(negedge CLK);
            while (!out_valid && k < 20) begin
               @(negedge CLK);
               k++;
            end
            for (int i = 0; i < 3*DEPTH; i++) begin
               check_output("t2_stream_valid", out_valid, 1);
               @(negedge CLK);
            end
         end
      join
      wait_drain(50);

      // Fill with the consumer stalled, then drain
      step();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      accepted  = 0;
      for (int c = 0; c < 4*DEPTH; c++) begin
         in_data = BL_WIDTH'(16'h0200 + accepted);
         @(negedge CLK);
         if (in_ready) accepted++;
         else if (accepted > 0) break;
         @(posedge CLK);
         #1;
      end
      step();
      in_valid = 1'b0;
      repeat (3) step();
      check_output("t3_accepted", accepted, DEPTH + 2);
      check_output("t3_occupancy_full", occupancy, DEPTH + 2);
      check_output("t3_in_ready_full", in_ready, 0);
`ifdef REG_MEM_FIFO_ERR_CHK_EN
      check_output("t6_err_set_on_full_push", err_sticky, 1);
`endif
      out_ready = 1'b1;
      step();
      check_output("t3_in_ready_after_first_pop", in_ready, 1);
      wait_drain(50);

      // Flush in the cycle after a read issue
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(BL_WIDTH'(16'h0300 + i));
      repeat (3) step();
      check_output("t5_occupancy_before", occupancy, 4);
      check_output("t5_head_before", out_data, 16'h0300);
      out_ready = 1'b1;
      step();
      flush = 1'b1;
      apply_stimulus(1'b1, 16'h0077, 1'b1);
      @(negedge CLK);
      check_output("t5_wr_en_forced_low", mem_wr_en, 0);
      check_output("t5_rd_en_forced_low", mem_rd_en, 0);
      @(posedge CLK);
      #1;
      flush = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0);
      check_output("t5_out_valid_after_flush", out_valid, 0);
      check_output("t5_occupancy_after_flush", occupancy, 0);
      check_output("t5_in_ready_after_flush", in_ready, 1);
`ifdef REG_MEM_FIFO_ERR_CHK_EN
      check_output("t6_err_cleared_by_flush", err_sticky, 0);
`endif
      push_word(16'h0005);
      out_ready = 1'b1;
      wait_valid(10);
      check_output("t5_next_word", out_data, 16'h0005);
      wait_drain(20);

      // Random traffic
      for (int c = 0; c < 10000; c++) begin
         apply_stimulus(1'($urandom_range(0, 1)), BL_WIDTH'($urandom), 1'($urandom_range(0, 1)));
         step();
      end
      wait_drain(50);

      // Reset in the middle of a transfer
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_word(BL_WIDTH'(16'h0400 + i));
      apply_stimulus(1'b1, 16'h0499, 1'b0);
      #2;
      rst_b = 1'b0;
      #1;
      check_output("midrst_out_valid", out_valid, 0);
      check_output("midrst_occupancy", occupancy, 0);
      check_output("midrst_in_ready", in_ready, 0);
      check_output("midrst_out_data", out_data, 0);
      in_valid = 1'b0;
      step();
      rst_b = 1'b1;
      step();
      check_output("midrst_in_ready_back", in_ready, 1);
      push_word(16'h0009);
      out_ready = 1'b1;
      wait_valid(10);
      check_output("midrst_next_word", out_data, 16'h0009);
      wait_drain(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
